// File: rtl/wb_stage_if.sv
// LSU-to-writeback bundle: instruction handoff, load data beat, forwarding/RF/commit outputs.
// slave = the writeback stage, master = the LSU/memory side that drives it.
interface wb_stage_if;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_isRegWrite;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_Wdata;
  logic        lsu_is_load;
  logic [1:0]  lsu_ld_size;
  logic        lsu_ld_unsigned;
  logic [2:0]  lsu_ld_offset;
  logic [63:0] lsu_pc;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_isRegWrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_Wdata;
  logic        wb_data_valid;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] retire_cnt;

  modport slave (
    input  lsu_valid, lsu_isRegWrite, lsu_rd, lsu_Wdata, lsu_is_load,
           lsu_ld_size, lsu_ld_unsigned, lsu_ld_offset, lsu_pc,
           mem_rvalid, mem_rdata,
    output lsu_ready, wb_isRegWrite, wb_rd, wb_Wdata, wb_data_valid,
           rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, retire_cnt
  );

  modport master (
    output lsu_valid, lsu_isRegWrite, lsu_rd, lsu_Wdata, lsu_is_load,
           lsu_ld_size, lsu_ld_unsigned, lsu_ld_offset, lsu_pc,
           mem_rvalid, mem_rdata,
    input  lsu_ready, wb_isRegWrite, wb_rd, wb_Wdata, wb_data_valid,
           rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, retire_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: one instruction in flight; non-loads commit 1 cycle after handshake, loads 1 cycle after mem_rvalid.
// Backpressure: lsu_ready drops only while a load beat is pending (WAIT).
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        isrw_q, isrw_d;
  logic [63:0] pc_q, pc_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] retire_q, retire_d;

  logic        hs;
  logic [63:0] shifted;
  logic [63:0] ld_ext;

  assign bus.lsu_ready = (state_q != WAIT);
  assign hs            = bus.lsu_valid && bus.lsu_ready;

  // Load controls are captured at handshake; the beat itself arrives later.
  assign shifted = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = shifted;
    case (size_q)
      2'd0:    ld_ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    ld_ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    ld_ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    isrw_d   = isrw_q;
    pc_d     = pc_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    retire_d = retire_q;

    if (hs) begin
      rd_d   = bus.lsu_rd;
      isrw_d = bus.lsu_isRegWrite;
      pc_d   = bus.lsu_pc;
      size_d = bus.lsu_ld_size;
      uns_d  = bus.lsu_ld_unsigned;
      off_d  = bus.lsu_ld_offset;
      if (bus.lsu_is_load) begin
        state_d = WAIT;
      end else begin
        state_d = DONE;
        wdata_d = bus.lsu_Wdata;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == WAIT && bus.mem_rvalid) begin
      state_d = DONE;
      wdata_d = ld_ext;
    end

    // Counter reflects the DONE cycle it is presented in.
    if (state_d == DONE) begin
      retire_d = retire_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_q     <= 5'd0;
      isrw_q   <= 1'b0;
      pc_q     <= 64'd0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      off_q    <= 3'd0;
      wdata_q  <= 64'd0;
      retire_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      isrw_q   <= isrw_d;
      pc_q     <= pc_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
    end
  end

  assign bus.wb_isRegWrite = (state_q != IDLE) && isrw_q && (rd_q != 5'd0);
  assign bus.wb_rd         = rd_q;
  assign bus.wb_Wdata      = wdata_q;
  assign bus.wb_data_valid = (state_q == DONE);
  assign bus.rf_wen        = (state_q == DONE) && bus.wb_isRegWrite;
  assign bus.rf_waddr      = rd_q;
  assign bus.rf_wdata      = wdata_q;
  assign bus.commit_valid  = (state_q == DONE);
  assign bus.commit_pc     = pc_q;
  assign bus.retire_cnt    = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: scoreboard of expected commits plus per-scenario inline checks.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if bus();
  wb_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_retire = 64'd0;

  // Commit monitor: every DONE cycle must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.commit_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_commit got pc=%h rf_wen=%b want no commit", bus.commit_pc, bus.rf_wen);
        end else begin
          mon_e = sb.pop_front();
          exp_retire = exp_retire + 64'd1;
          checks++;
          if (bus.rf_wen !== mon_e.wen || bus.rf_waddr !== mon_e.rd ||
              bus.rf_wdata !== mon_e.data || bus.commit_pc !== mon_e.pc) begin
            failures++;
            $display("FAIL commit got wen=%b waddr=%0d wdata=%h pc=%h want wen=%b waddr=%0d wdata=%h pc=%h",
                     bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.commit_pc,
                     mon_e.wen, mon_e.rd, mon_e.data, mon_e.pc);
          end
          checks++;
          if (bus.retire_cnt !== exp_retire) begin
            failures++;
            $display("FAIL retire_cnt got %0d want %0d", bus.retire_cnt, exp_retire);
          end
          checks++;
          if (bus.wb_Wdata !== mon_e.data || bus.wb_isRegWrite !== mon_e.wen) begin
            failures++;
            $display("FAIL fwd_port got wb_Wdata=%h wb_isRegWrite=%b want %h %b",
                     bus.wb_Wdata, bus.wb_isRegWrite, mon_e.data, mon_e.wen);
          end
        end
      end else begin
        checks++;
        if (bus.rf_wen !== 1'b0 || bus.wb_data_valid !== 1'b0) begin
          failures++;
          $display("FAIL idle_write got rf_wen=%b wb_data_valid=%b want 0 0", bus.rf_wen, bus.wb_data_valid);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.lsu_valid       = 1'b0;
    bus.lsu_isRegWrite  = 1'b0;
    bus.lsu_rd          = 5'd0;
    bus.lsu_Wdata       = 64'd0;
    bus.lsu_is_load     = 1'b0;
    bus.lsu_ld_size     = 2'd0;
    bus.lsu_ld_unsigned = 1'b0;
    bus.lsu_ld_offset   = 3'd0;
    bus.lsu_pc          = 64'd0;
    bus.mem_rvalid      = 1'b0;
    bus.mem_rdata       = 64'd0;
  endtask

  // Entered and left at posedge+1; the handshake happens on the intervening edge.
  task automatic drive_op(input logic ld, input logic [1:0] sz, input logic uns, input logic [2:0] off,
                          input logic isrw, input logic [4:0] rd, input logic [63:0] wdata,
                          input logic [63:0] pc, input logic [63:0] exp_data, input logic push);
    bus.lsu_valid       = 1'b1;
    bus.lsu_is_load     = ld;
    bus.lsu_ld_size     = sz;
    bus.lsu_ld_unsigned = uns;
    bus.lsu_ld_offset   = off;
    bus.lsu_isRegWrite  = isrw;
    bus.lsu_rd          = rd;
    bus.lsu_Wdata       = wdata;
    bus.lsu_pc          = pc;
    @(negedge clk);
    checks++;
    if (bus.lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL lsu_ready_at_handshake got %b want 1", bus.lsu_ready);
    end
    if (push) sb.push_back('{wen: isrw && (rd != 5'd0), rd: rd, data: exp_data, pc: pc});
    @(posedge clk); #1;
    bus.lsu_valid = 1'b0;
    bus.lsu_Wdata = 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_retire = 64'd0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.wb_isRegWrite !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_Wdata !== 64'd0 || bus.wb_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_wb got isrw=%b rd=%0d wdata=%h dv=%b want all 0",
               bus.wb_isRegWrite, bus.wb_rd, bus.wb_Wdata, bus.wb_data_valid);
    end
    checks++;
    if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 64'd0 ||
        bus.commit_valid !== 1'b0 || bus.commit_pc !== 64'd0 || bus.retire_cnt !== 64'd0) begin
      failures++;
      $display("FAIL reset_rf_commit got wen=%b waddr=%0d wdata=%h cv=%b pc=%h cnt=%0d want all 0",
               bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.commit_valid, bus.commit_pc, bus.retire_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b want 1", bus.lsu_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nonload();
    drive_op(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 5'd5, 64'h1234, 64'h1000, 64'h1234, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 64'h1234 ||
        bus.wb_data_valid !== 1'b1 || bus.retire_cnt !== 64'd1) begin
      failures++;
      $display("FAIL nonload got wen=%b waddr=%0d wdata=%h dv=%b cnt=%0d want 1 5 1234 1 1",
               bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.wb_data_valid, bus.retire_cnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.wb_data_valid !== 1'b0 || bus.wb_isRegWrite !== 1'b0 || bus.lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL nonload_idle got dv=%b isrw=%b ready=%b want 0 0 1",
               bus.wb_data_valid, bus.wb_isRegWrite, bus.lsu_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_load(input string name, input logic [1:0] sz, input logic uns, input logic [2:0] off,
                         input logic [63:0] rdata, input logic isrw, input logic [4:0] rd,
                         input logic [63:0] pc, input logic [63:0] exp_data, input int gap);
    drive_op(1'b1, sz, uns, off, isrw, rd, 64'hDEAD_BEEF_DEAD_BEEF, pc, exp_data, 1'b1);
    for (int i = 0; i < gap - 1; i++) begin
      @(negedge clk);
      checks++;
      if (bus.lsu_ready !== 1'b0 || bus.wb_data_valid !== 1'b0 ||
          bus.wb_isRegWrite !== (isrw && (rd != 5'd0))) begin
        failures++;
        $display("FAIL %s_wait got ready=%b dv=%b isrw=%b want 0 0 %b",
                 name, bus.lsu_ready, bus.wb_data_valid, bus.wb_isRegWrite, isrw && (rd != 5'd0));
      end
      @(posedge clk); #1;
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = ~rdata;
    @(negedge clk);
    checks++;
    if (bus.rf_wdata !== exp_data || bus.wb_data_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s got rf_wdata=%h dv=%b want %h 1", name, bus.rf_wdata, bus.wb_data_valid, exp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    do_load("ld_byte_s_off3", 2'd0, 1'b0, 3'd3, 64'h0000_0000_80FF_0000, 1'b1, 5'd7, 64'h2000, 64'hFFFF_FFFF_FFFF_FF80, 3);
    do_load("ld_half_u",      2'd1, 1'b1, 3'd0, 64'h1111_2222_3333_8001, 1'b1, 5'd8, 64'h2004, 64'h0000_0000_0000_8001, 2);
    do_load("ld_word_s",      2'd2, 1'b0, 3'd0, 64'h0000_0000_8000_0000, 1'b1, 5'd9, 64'h2008, 64'hFFFF_FFFF_8000_0000, 1);
    do_load("ld_byte_u_off7", 2'd0, 1'b1, 3'd7, 64'hAB12_3456_789A_BCDE, 1'b1, 5'd10, 64'h200C, 64'h0000_0000_0000_00AB, 2);
    do_load("ld_half_s_off6", 2'd1, 1'b0, 3'd6, 64'hAB12_3456_789A_BCDE, 1'b1, 5'd11, 64'h2010, 64'hFFFF_FFFF_FFFF_AB12, 1);
    do_load("ld_word_u_off4", 2'd2, 1'b1, 3'd4, 64'hAB12_3456_789A_BCDE, 1'b1, 5'd12, 64'h2014, 64'h0000_0000_AB12_3456, 2);
    do_load("ld_dbl_uflag",   2'd3, 1'b1, 3'd0, 64'hAB12_3456_789A_BCDE, 1'b1, 5'd13, 64'h2018, 64'hAB12_3456_789A_BCDE, 1);
    do_load("ld_rd0",         2'd0, 1'b0, 3'd0, 64'h0000_0000_0000_0042, 1'b1, 5'd0, 64'h201C, 64'h0000_0000_0000_0042, 2);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive_op(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 5'd1, 64'h11, 64'h100, 64'h11, 1'b1);
    drive_op(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 5'd2, 64'h22, 64'h104, 64'h22, 1'b1);
    drive_op(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 5'd0, 64'h33, 64'h108, 64'h33, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.retire_cnt !== 64'd3 || bus.commit_valid !== 1'b1 || bus.rf_wen !== 1'b0 || bus.lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back got cnt=%0d cv=%b wen=%b ready=%b want 3 1 0 1",
               bus.retire_cnt, bus.commit_valid, bus.rf_wen, bus.lsu_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    drive_op(1'b1, 2'd3, 1'b0, 3'd0, 1'b1, 5'd4, 64'd0, 64'h3000, 64'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.lsu_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_pre got ready=%b want 0", bus.lsu_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_retire = 64'd0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rf_wen !== 1'b0 || bus.commit_valid !== 1'b0 || bus.lsu_ready !== 1'b1 || bus.retire_cnt !== 64'd0) begin
        failures++;
        $display("FAIL rst_wait got wen=%b cv=%b ready=%b cnt=%0d want 0 0 1 0",
                 bus.rf_wen, bus.commit_valid, bus.lsu_ready, bus.retire_cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rvalid_idle();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.wb_data_valid !== 1'b0 || bus.commit_valid !== 1'b0 || bus.wb_isRegWrite !== 1'b0 ||
          bus.wb_Wdata !== 64'd0 || bus.retire_cnt !== exp_retire) begin
        failures++;
        $display("FAIL rvalid_idle got dv=%b cv=%b isrw=%b wdata=%h cnt=%0d want 0 0 0 0 %0d",
                 bus.wb_data_valid, bus.commit_valid, bus.wb_isRegWrite, bus.wb_Wdata, bus.retire_cnt, exp_retire);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_nonload();
    test_loads();
    test_back_to_back();
    test_reset_in_wait();
    test_rvalid_idle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
